// File: rtl/vga_face_pkg.sv
// Shared types for the face scheduler and its benches.
package vga_face_pkg;

  typedef enum logic [1:0] {
    FaceWolf  = 2'd0,
    FaceP2    = 2'd1,
    FaceTroll = 2'd2
  } face_t;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StShow,
    StShowArmed
  } sched_state_e;

  localparam int unsigned NumPixels = 640 * 480;

endpackage

// File: rtl/vga_face_scheduler_if.sv
// Requester bus plus the snooped streamer handshake seen by the face scheduler.
interface vga_face_scheduler_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned HOLD_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [2*NUM_REQ-1:0]      req_face;
  logic [HOLD_W*NUM_REQ-1:0] req_frames;
  logic [NUM_REQ-1:0]        grant;
  logic                      st_valid;
  logic                      st_ready;
  logic                      st_endofpacket;

  modport master (
    output req, req_face, req_frames, st_valid, st_ready, st_endofpacket,
    input  grant
  );

  modport slave (
    input  req, req_face, req_frames, st_valid, st_ready, st_endofpacket,
    output grant
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic                       en,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx
);
  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic        found;
  int unsigned cand;

  // Scan NUM_REQ positions starting at ptr, wrapping past the top index.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/vga_face_scheduler.sv
// Frame-synchronous face scheduler: grants requesters round-robin and swaps
// face_select only on the streamer's end-of-frame handshake.
module vga_face_scheduler
  import vga_face_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned HOLD_W       = 8,
  parameter face_t       DEFAULT_FACE = FaceWolf
) (
  input  logic                       clk,
  input  logic                       reset,
  vga_face_scheduler_if.slave        bus,
  output logic [1:0]                 face_select,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy,
  output logic                       frame_tick
);
  localparam int unsigned IdxW = $clog2(NUM_REQ);

  sched_state_e      state_q, state_d;
  logic [1:0]        face_q, face_d, pend_face_q, pend_face_d;
  logic [HOLD_W-1:0] rem_q, rem_d, pend_frames_q, pend_frames_d;
  logic [IdxW-1:0]   owner_q, owner_d, pend_idx_q, pend_idx_d, ptr_q, ptr_d;
  logic              tick_q;

  logic              fb, rem_one, arb_en, granted;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IdxW-1:0]   arb_idx;
  int unsigned       sel;

  assign fb      = bus.st_valid & bus.st_ready & bus.st_endofpacket;
  assign rem_one = (rem_q == HOLD_W'(1));
  // Only one grant may be pending; SHOW accepts the next one in its last frame.
  assign arb_en  = (state_q == StIdle) || ((state_q == StShow) && rem_one);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req   (bus.req),
    .ptr   (ptr_q),
    .en    (arb_en),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign bus.grant   = arb_grant;
  assign granted     = |arb_grant;
  assign sel         = 32'(arb_idx);
  assign face_select = face_q;
  assign owner       = owner_q;
  assign busy        = (state_q == StShow) || (state_q == StShowArmed);
  assign frame_tick  = tick_q;

  // Next-state: latch grants into the pending slot, move faces on frame boundaries.
  always_comb begin
    state_d       = state_q;
    face_d        = face_q;
    rem_d         = rem_q;
    owner_d       = owner_q;
    pend_face_d   = pend_face_q;
    pend_frames_d = pend_frames_q;
    pend_idx_d    = pend_idx_q;
    ptr_d         = ptr_q;

    if (granted) begin
      pend_face_d   = bus.req_face[2*sel +: 2];
      pend_frames_d = bus.req_frames[HOLD_W*sel +: HOLD_W];
      pend_idx_d    = arb_idx;
      ptr_d         = (arb_idx == IdxW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        // A grant coinciding with fb still waits a full frame.
        if (granted) state_d = StArmed;
      end
      StArmed, StShowArmed: begin
        if (fb) begin
          face_d        = pend_face_q;
          rem_d         = (pend_frames_q == '0) ? HOLD_W'(1) : pend_frames_q;
          owner_d       = pend_idx_q;
          pend_face_d   = '0;
          pend_frames_d = '0;
          pend_idx_d    = '0;
          state_d       = StShow;
        end
      end
      StShow: begin
        if (fb && rem_one) begin
          face_d  = DEFAULT_FACE;
          rem_d   = '0;
          state_d = granted ? StArmed : StIdle;
        end else begin
          if (fb) rem_d = rem_q - 1'b1;
          if (granted) state_d = StShowArmed;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      face_q        <= DEFAULT_FACE;
      rem_q         <= '0;
      owner_q       <= '0;
      pend_face_q   <= '0;
      pend_frames_q <= '0;
      pend_idx_q    <= '0;
      ptr_q         <= '0;
      tick_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      face_q        <= face_d;
      rem_q         <= rem_d;
      owner_q       <= owner_d;
      pend_face_q   <= pend_face_d;
      pend_frames_q <= pend_frames_d;
      pend_idx_q    <= pend_idx_d;
      ptr_q         <= ptr_d;
      tick_q        <= fb;
    end
  end

endmodule

// File: tb/tb_vga_face_scheduler.sv
// Self-checking bench for vga_face_scheduler: directed table, corner sequences,
// and randomized traffic against a frame-level reference model.
module tb_vga_face_scheduler;
  import vga_face_pkg::*;

  localparam int N  = 3;
  localparam int HW = 8;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] face_select;
  logic [1:0] owner;
  logic       busy;
  logic       frame_tick;

  vga_face_scheduler_if #(.NUM_REQ(N), .HOLD_W(HW)) bus ();

  vga_face_scheduler #(
    .NUM_REQ      (N),
    .HOLD_W       (HW),
    .DEFAULT_FACE (FaceWolf)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .face_select (face_select),
    .owner       (owner),
    .busy        (busy),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  // Reference model: what is on screen, how many frames remain, and a queue of
  // accepted-but-not-yet-shown requests.
  typedef struct {
    logic [1:0] face;
    int         frames;
    int         idx;
  } pend_t;

  pend_t      pend_q[$];
  bit         m_shown;
  logic [1:0] m_face;
  int         m_owner;
  int         m_left;
  int         m_ptr;
  bit         m_tick;

  logic [N-1:0] last_grant;
  int           last_w;
  int           tick_cnt;
  int           face3_cnt;

  task automatic model_reset();
    pend_q.delete();
    m_shown = 1'b0;
    m_face  = 2'd0;
    m_owner = 0;
    m_left  = 0;
    m_ptr   = 0;
    m_tick  = 1'b0;
  endtask

  // A new request is accepted only with nothing queued and either nothing on
  // screen or the current face in its final frame.
  function automatic int model_winner(input logic [N-1:0] r);
    if (pend_q.size() != 0) return -1;
    if (m_shown && m_left != 1) return -1;
    for (int k = 0; k < N; k++) begin
      if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_edge(input bit fb, input int w);
    pend_t p;
    if (fb) begin
      if (pend_q.size() != 0) begin
        p       = pend_q.pop_front();
        m_shown = 1'b1;
        m_face  = p.face;
        m_owner = p.idx;
        m_left  = (p.frames == 0) ? 1 : p.frames;
      end else if (m_shown) begin
        m_left--;
        if (m_left == 0) begin
          m_shown = 1'b0;
          m_face  = 2'd0;
        end
      end
    end
    if (w >= 0) begin
      p.face   = bus.req_face[2*w +: 2];
      p.frames = int'(bus.req_frames[HW*w +: HW]);
      p.idx    = w;
      pend_q.push_back(p);
      m_ptr = (w + 1) % N;
    end
    m_tick = fb;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input logic [N-1:0] r, input bit v, input bit rd, input bit e);
    int           w;
    bit           fb;
    logic [N-1:0] eg;
    bus.req            = r;
    bus.st_valid       = v;
    bus.st_ready       = rd;
    bus.st_endofpacket = e;
    #2;
    fb = v && rd && e;
    w  = model_winner(r);
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    last_grant = bus.grant;
    last_w     = w;
    check("grant", 32'(bus.grant), 32'(eg));
    @(posedge clk);
    model_edge(fb, w);
    #1;
    check("face_select", 32'(face_select), 32'(m_face));
    check("busy", 32'(busy), 32'(m_shown));
    check("frame_tick", 32'(frame_tick), 32'(m_tick));
    if (m_shown) check("owner", 32'(owner), m_owner);
    if (frame_tick) tick_cnt++;
    if (face_select == 2'd3) face3_cnt++;
    @(negedge clk);
  endtask

  task automatic frame(input int len, input logic [N-1:0] r);
    for (int c = 0; c < len; c++) step(r, c == len - 1, c == len - 1, c == len - 1);
  endtask

  task automatic do_reset();
    bus.req            = '0;
    bus.st_valid       = 1'b0;
    bus.st_ready       = 1'b0;
    bus.st_endofpacket = 1'b0;
    reset              = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] req;
    bit           fb;
    logic [N-1:0] exp_grant;
    logic [1:0]   exp_face;
    bit           exp_busy;
  } vec_t;

  vec_t tbl[12];
  int   gq[$];

  initial begin
    bit  busy_seen;
    int  gaps;
    logic [N-1:0] r;

    // Single request (req[1], face 2, 3 frames), then a same-cycle grant+fb.
    tbl[0]  = '{3'b000, 1'b0, 3'b000, 2'd0, 1'b0};
    tbl[1]  = '{3'b010, 1'b0, 3'b010, 2'd0, 1'b0};
    tbl[2]  = '{3'b000, 1'b0, 3'b000, 2'd0, 1'b0};
    tbl[3]  = '{3'b000, 1'b1, 3'b000, 2'd2, 1'b1};
    tbl[4]  = '{3'b000, 1'b0, 3'b000, 2'd2, 1'b1};
    tbl[5]  = '{3'b000, 1'b1, 3'b000, 2'd2, 1'b1};
    tbl[6]  = '{3'b000, 1'b1, 3'b000, 2'd2, 1'b1};
    tbl[7]  = '{3'b000, 1'b1, 3'b000, 2'd0, 1'b0};
    tbl[8]  = '{3'b000, 1'b0, 3'b000, 2'd0, 1'b0};
    tbl[9]  = '{3'b010, 1'b1, 3'b010, 2'd0, 1'b0};
    tbl[10] = '{3'b000, 1'b0, 3'b000, 2'd0, 1'b0};
    tbl[11] = '{3'b000, 1'b1, 3'b000, 2'd2, 1'b1};

    bus.req_face   = '0;
    bus.req_frames = '0;

    // Reset and idle frames.
    do_reset();
    #1;
    check("rst_face", 32'(face_select), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);
    check("rst_grant", 32'(bus.grant), 32'd0);
    @(negedge clk);
    tick_cnt = 0;
    frame(8, '0);
    frame(8, '0);
    check("idle_ticks", tick_cnt, 2);

    // Directed table.
    do_reset();
    bus.req_face   = {2'd0, 2'd2, 2'd0};
    bus.req_frames = {8'd0, 8'd3, 8'd0};
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].req, tbl[i].fb, tbl[i].fb, tbl[i].fb);
      check("tbl_grant", 32'(last_grant), 32'(tbl[i].exp_grant));
      check("tbl_face", 32'(face_select), 32'(tbl[i].exp_face));
      check("tbl_busy", 32'(busy), 32'(tbl[i].exp_busy));
      if (tbl[i].exp_busy) check("tbl_owner", 32'(owner), 32'd1);
    end

    // Round-robin with all requesters held, one frame each.
    do_reset();
    bus.req_face   = {2'd3, 2'd2, 2'd1};
    bus.req_frames = {8'd1, 8'd1, 8'd1};
    busy_seen = 1'b0;
    gaps      = 0;
    for (int f = 0; f < 5; f++) begin
      for (int c = 0; c < 6; c++) begin
        step(3'b111, c == 5, c == 5, c == 5);
        if (last_w >= 0) gq.push_back(last_w);
        if (busy) busy_seen = 1'b1;
        else if (busy_seen) gaps++;
      end
    end
    for (int k = 0; k < 4; k++) check("rr_order", (k < gq.size()) ? gq[k] : 99, k % 3);
    check("rr_gaps", gaps, 0);

    // Zero hold with face code 3: exactly one frame (6 cycles) of face 3.
    do_reset();
    bus.req_face   = {2'd0, 2'd0, 2'd3};
    bus.req_frames = {8'd0, 8'd0, 8'd0};
    face3_cnt = 0;
    step(3'b001, 1'b0, 1'b0, 1'b0);
    frame(6, '0);
    frame(6, '0);
    frame(6, '0);
    check("code3_cycles", face3_cnt, 6);

    // Reset in the middle of a 5-frame hold with the next grant pending.
    do_reset();
    bus.req_face   = {2'd2, 2'd0, 2'd1};
    bus.req_frames = {8'd2, 8'd0, 8'd5};
    step(3'b001, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c <= 100; c++) step(3'b100, (c % 20) == 19, (c % 20) == 19, (c % 20) == 19);
    check("pre_rst_face", 32'(face_select), 32'd1);
    bus.req = '0;
    #2;
    reset = 1'b0;
    #1;
    check("async_face", 32'(face_select), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_owner", 32'(owner), 32'd0);
    check("async_tick", 32'(frame_tick), 32'd0);
    check("async_grant", 32'(bus.grant), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    frame(8, '0);
    frame(8, '0);
    check("pending_lost", 32'(face_select), 32'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.req_face = 6'($urandom);
        for (int i = 0; i < N; i++) bus.req_frames[HW*i +: HW] = 8'($urandom_range(0, 3));
      end
      r = 3'($urandom_range(0, 7));
      step(r, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
